// File: rtl/systolic_1xn_pkg.sv
// Shared types and helpers for the 1xN systolic multiply-accumulate row.
package systolic_pkg;

  // Widest accumulator the extension helper can produce.
  localparam int unsigned MAX_AW = 128;

  // Control half of a token; the b operand travels beside it at width DW.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tok_ctl_t;

  // Sign- or zero-extends a pw-bit product to MAX_AW bits.
  function automatic logic [MAX_AW-1:0] ext_prod(input logic [MAX_AW-1:0] p,
                                                 input int unsigned pw,
                                                 input bit sgn);
    logic [MAX_AW-1:0] r;
    r = p;
    for (int unsigned i = 0; i < MAX_AW; i++) begin
      if (i >= pw) r[i] = sgn & p[pw-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_1xn_if.sv
// Token link between neighbouring PEs: streaming operand b plus valid/first/last.
interface systolic_1xn_if #(
  parameter int DW = 16
);
  import systolic_pkg::*;

  logic [DW-1:0] b;
  tok_ctl_t      ctl;

  modport master (output b, ctl);
  modport slave  (input  b, ctl);
endinterface

// File: rtl/systolic_1xn_pe.sv
// One processing element: token register, stationary-operand MAC and c_valid bit.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 32,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DW-1:0]     a_i,
  systolic_1xn_if.slave     tok_i,
  systolic_1xn_if.master    tok_o,
  output logic [AW-1:0]     acc_o,
  output logic              c_valid_o
);

  localparam bit SGN = (SIGNED != 0);

  logic [DW-1:0]     b_q;
  tok_ctl_t          ctl_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_d;
  logic              c_valid_q;

  logic [2*DW-1:0]   a_x;
  logic [2*DW-1:0]   b_x;
  logic [2*DW-1:0]   prod;
  logic [MAX_AW-1:0] prod_ext;

  // Pre-extending both operands to 2*DW lets one unsigned multiply serve both modes.
  assign a_x      = {{DW{SGN & a_i[DW-1]}}, a_i};
  assign b_x      = {{DW{SGN & tok_i.b[DW-1]}}, tok_i.b};
  assign prod     = a_x * b_x;
  assign prod_ext = ext_prod(MAX_AW'(prod), 2 * DW, SGN);
  assign acc_d    = (tok_i.ctl.first ? '0 : acc_q) + prod_ext[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q       <= '0;
      ctl_q     <= '0;
      acc_q     <= '0;
      c_valid_q <= 1'b0;
    end else if (en) begin
      b_q       <= tok_i.b;
      ctl_q     <= tok_i.ctl;
      c_valid_q <= tok_i.ctl.valid & tok_i.ctl.last;
      if (tok_i.ctl.valid) acc_q <= acc_d;
    end
  end

  assign tok_o.b   = b_q;
  assign tok_o.ctl = ctl_q;
  assign acc_o     = acc_q;
  assign c_valid_o = c_valid_q;

endmodule

// File: rtl/systolic_1xn.sv
// Parametrised 1xN systolic MAC row: b ripples one PE per enabled edge, a_k stays put.
module systolic_1xn
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int AW     = 32,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic            in_first,
  input  logic            in_last,
  input  logic [N*DW-1:0] a_flat,
  input  logic [DW-1:0]   b_in,
  output logic [N*AW-1:0] c_flat,
  output logic [N-1:0]    c_valid,
  output logic [DW-1:0]   b_out,
  output logic            b_out_valid,
  output logic            done,
  output logic            busy
);

  if (N < 1) begin : g_bad_n
    $error("systolic_1xn: N must be at least 1");
  end
  if (AW < 2 * DW || AW > int'(MAX_AW)) begin : g_bad_aw
    $error("systolic_1xn: AW must be within [2*DW, MAX_AW]");
  end

  // link[k] is the token seen by PE k; link[N] is the cascade output.
  systolic_1xn_if #(.DW(DW)) link [N+1] ();

  logic [N-1:0] tok_valid;
  logic         unused_tail;

  assign link[0].b   = b_in;
  assign link[0].ctl = '{valid: in_valid, first: in_first, last: in_last};

  for (genvar k = 0; k < N; k++) begin : g_pe
    systolic_pe #(
      .DW     (DW),
      .AW     (AW),
      .SIGNED (SIGNED)
    ) u_pe (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .a_i       (a_flat[k*DW +: DW]),
      .tok_i     (link[k]),
      .tok_o     (link[k+1]),
      .acc_o     (c_flat[k*AW +: AW]),
      .c_valid_o (c_valid[k])
    );
    assign tok_valid[k] = link[k+1].ctl.valid;
  end

  assign b_out       = link[N].b;
  assign b_out_valid = link[N].ctl.valid;
  assign done        = c_valid[N-1];
  assign busy        = in_valid | (|tok_valid);
  assign unused_tail = link[N].ctl.first ^ link[N].ctl.last;

endmodule

// File: tb/tb_systolic_1xn.sv
// Bench for systolic_1xn: an unsigned 4-PE row and a signed 2-PE row share one stimulus stream.
module tb_systolic_1xn;
  import systolic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [63:0] a_u;
  logic [31:0] a_s;

  systolic_1xn_if #(.DW(16)) stim ();

  logic [127:0] c_u;
  logic [3:0]   cv_u;
  logic [15:0]  bo_u;
  logic         bov_u, done_u, busy_u;
  logic [63:0]  c_s;
  logic [1:0]   cv_s;
  logic [15:0]  bo_s;
  logic         bov_s, done_s, busy_s;

  always #5 clk = ~clk;

  systolic_1xn #(.N(4), .DW(16), .AW(32), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(stim.ctl.valid), .in_first(stim.ctl.first), .in_last(stim.ctl.last),
    .a_flat(a_u), .b_in(stim.b),
    .c_flat(c_u), .c_valid(cv_u), .b_out(bo_u), .b_out_valid(bov_u),
    .done(done_u), .busy(busy_u)
  );

  systolic_1xn #(.N(2), .DW(16), .AW(32), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(stim.ctl.valid), .in_first(stim.ctl.first), .in_last(stim.ctl.last),
    .a_flat(a_s), .b_in(stim.b),
    .c_flat(c_s), .c_valid(cv_s), .b_out(bo_s), .b_out_valid(bov_s),
    .done(done_s), .busy(busy_s)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of port tokens, newest first. hist[k] is the
  // beat PE k consumed at the most recent enabled edge.
  typedef struct {
    logic [15:0] b;
    bit          v, f, l;
  } mtok_t;

  mtok_t       hist[$];
  logic [31:0] acc_u[4];
  logic [31:0] acc_s[2];
  bit          mcv_u[4];
  bit          mcv_s[2];

  function automatic logic [31:0] mprod(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  function automatic mtok_t hist_at(input int k);
    mtok_t z;
    z = '{b: 16'h0, v: 1'b0, f: 1'b0, l: 1'b0};
    if (hist.size() > k) return hist[k];
    return z;
  endfunction

  task automatic model_edge();
    mtok_t cur, t;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 4; k++) begin acc_u[k] = '0; mcv_u[k] = 0; end
      for (int k = 0; k < 2; k++) begin acc_s[k] = '0; mcv_s[k] = 0; end
    end else if (en) begin
      cur = '{b: stim.b, v: stim.ctl.valid, f: stim.ctl.first, l: stim.ctl.last};
      hist.push_front(cur);
      while (hist.size() > 8) void'(hist.pop_back());
      for (int k = 0; k < 4; k++) begin
        t = hist_at(k);
        mcv_u[k] = t.v & t.l;
        if (t.v) acc_u[k] = (t.f ? 32'h0 : acc_u[k]) + mprod(a_u[k*16 +: 16], t.b, 1'b0);
      end
      for (int k = 0; k < 2; k++) begin
        t = hist_at(k);
        mcv_s[k] = t.v & t.l;
        if (t.v) acc_s[k] = (t.f ? 32'h0 : acc_s[k]) + mprod(a_s[k*16 +: 16], t.b, 1'b1);
      end
    end
  endtask

  task automatic compare_all();
    mtok_t t;
    bit    bz;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("c_u%0d", k), 64'(c_u[k*32 +: 32]), 64'(acc_u[k]));
      check($sformatf("cv_u%0d", k), 64'(cv_u[k]), 64'(mcv_u[k]));
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("c_s%0d", k), 64'(c_s[k*32 +: 32]), 64'(acc_s[k]));
      check($sformatf("cv_s%0d", k), 64'(cv_s[k]), 64'(mcv_s[k]));
    end
    t = hist_at(3);
    check("b_out_u", 64'(bo_u), 64'(t.b));
    check("b_out_valid_u", 64'(bov_u), 64'(t.v));
    check("done_u", 64'(done_u), 64'(mcv_u[3]));
    bz = stim.ctl.valid;
    for (int k = 0; k < 4; k++) bz |= hist_at(k).v;
    check("busy_u", 64'(busy_u), 64'(bz));
    t = hist_at(1);
    check("b_out_s", 64'(bo_s), 64'(t.b));
    check("b_out_valid_s", 64'(bov_s), 64'(t.v));
    check("done_s", 64'(done_s), 64'(mcv_s[1]));
    bz = stim.ctl.valid | hist_at(0).v | hist_at(1).v;
    check("busy_s", 64'(busy_s), 64'(bz));
  endtask

  task automatic drive(input bit r, input bit e, input bit v, input bit f, input bit l,
                       input logic [15:0] b);
    rst = r;
    en = e;
    stim.ctl = '{valid: v, first: f, last: l};
    stim.b = b;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    bit          v, f, l;
    logic [15:0] b;
    logic [31:0] c0, c1, c3;
    logic [3:0]  cv;
    bit          bov;
    logic [15:0] bo;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 1, 0, 16'd5,  32'd25,  32'd0,   32'd0,   4'b0000, 0, 16'd0};
    tbl[1] = '{1, 0, 0, 16'd10, 32'd75,  32'd25,  32'd0,   4'b0000, 0, 16'd0};
    tbl[2] = '{1, 0, 1, 16'd20, 32'd175, 32'd75,  32'd0,   4'b0001, 0, 16'd0};
    tbl[3] = '{0, 0, 0, 16'd0,  32'd175, 32'd175, 32'd25,  4'b0010, 1, 16'd5};
    tbl[4] = '{0, 0, 0, 16'd0,  32'd175, 32'd175, 32'd75,  4'b0100, 1, 16'd10};
    tbl[5] = '{0, 0, 0, 16'd0,  32'd175, 32'd175, 32'd175, 4'b1000, 1, 16'd20};
    tbl[6] = '{0, 0, 0, 16'd0,  32'd175, 32'd175, 32'd175, 4'b0000, 0, 16'd0};

    a_u = {4{16'd5}};
    a_s = {16'd7, 16'hFFFD};
    drive(1, 0, 1, 1, 1, 16'hABCD);
    drive(1, 1, 0, 0, 0, 16'h0);
    check("reset_c_u", 64'(c_u[63:0]), 64'h0);
    check("reset_busy_u", 64'(busy_u), 64'h0);

    // Three-beat tile on consecutive enabled edges.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].b);
      check($sformatf("tbl%0d_c0", i), 64'(c_u[31:0]), 64'(tbl[i].c0));
      check($sformatf("tbl%0d_c1", i), 64'(c_u[63:32]), 64'(tbl[i].c1));
      check($sformatf("tbl%0d_c3", i), 64'(c_u[127:96]), 64'(tbl[i].c3));
      check($sformatf("tbl%0d_cv", i), 64'(cv_u), 64'(tbl[i].cv));
      check($sformatf("tbl%0d_done", i), 64'(done_u), 64'(tbl[i].cv[3]));
      check($sformatf("tbl%0d_bov", i), 64'(bov_u), 64'(tbl[i].bov));
      check($sformatf("tbl%0d_bo", i), 64'(bo_u), 64'(tbl[i].bo));
    end

    // Same tile with a two-cycle stall before the last beat.
    drive(0, 1, 1, 1, 0, 16'd5);
    drive(0, 1, 1, 0, 0, 16'd10);
    drive(0, 0, 1, 0, 1, 16'd20);
    check("stall_c0_frozen", 64'(c_u[31:0]), 64'd75);
    drive(0, 0, 1, 0, 1, 16'd20);
    check("stall_c1_frozen", 64'(c_u[63:32]), 64'd25);
    drive(0, 1, 1, 0, 1, 16'd20);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 16'd0);
    check("stall_done", 64'(done_u), 64'd1);
    check("stall_c3", 64'(c_u[127:96]), 64'd175);
    drive(0, 1, 0, 0, 0, 16'd0);
    check("stall_done_drop", 64'(done_u), 64'd0);

    // Signed single-beat tile in dut_s.
    drive(0, 1, 1, 1, 1, 16'd4);
    check("signed_c0", 64'(c_s[31:0]), 64'hFFFF_FFF4);
    check("signed_cv0", 64'(cv_s[0]), 64'd1);
    drive(0, 1, 0, 0, 0, 16'd0);
    check("signed_cv0_drop", 64'(cv_s[0]), 64'd0);

    // Accumulator wrap.
    a_u = {4{16'hFFFF}};
    drive(0, 1, 1, 1, 0, 16'hFFFF);
    check("wrap_c0_a", 64'(c_u[31:0]), 64'hFFFE_0001);
    drive(0, 1, 1, 0, 1, 16'hFFFF);
    check("wrap_c0_b", 64'(c_u[31:0]), 64'hFFFC_0002);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 16'd0);

    // Back-to-back tiles without a bubble.
    a_u = {4{16'd5}};
    drive(0, 1, 1, 1, 0, 16'd1);
    check("b2b_c0_a", 64'(c_u[31:0]), 64'd5);
    drive(0, 1, 1, 0, 1, 16'd2);
    check("b2b_c0_b", 64'(c_u[31:0]), 64'd15);
    check("b2b_cv0_a", 64'(cv_u[0]), 64'd1);
    drive(0, 1, 1, 1, 1, 16'd3);
    check("b2b_c0_c", 64'(c_u[31:0]), 64'd15);
    check("b2b_cv0_c", 64'(cv_u[0]), 64'd1);
    drive(0, 1, 0, 0, 0, 16'd0);
    check("b2b_cv0_drop", 64'(cv_u[0]), 64'd0);

    // Reset in the middle of a tile.
    drive(0, 1, 1, 1, 0, 16'd7);
    drive(0, 1, 1, 0, 0, 16'd8);
    drive(1, 1, 0, 0, 0, 16'd0);
    check("rst_c_u", 64'(c_u[63:0] | c_u[127:64]), 64'h0);
    check("rst_cv_u", 64'(cv_u), 64'h0);
    check("rst_busy_u", 64'(busy_u), 64'h0);
    check("rst_bov_u", 64'(bov_u), 64'h0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 16'd0);
      check($sformatf("rst_idle_cv%0d", i), 64'(cv_u), 64'h0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        a_u = {$urandom(), $urandom()};
        a_s = $urandom();
      end
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, 16'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
